// File: rtl/fft_fifo_pkg.sv
// Shared constants for the FFT stage-buffer FIFO: default geometry,
// read-latency encodings and the occupancy-counter width helper.
package fft_fifo_pkg;

   localparam int DEF_WIDTH    = 14;
   localparam int DEF_ADDR_W   = 3;
   localparam int DEF_AFULL_TH = 6;

   localparam int RD_COMB = 0;
   localparam int RD_REG  = 1;

   // Occupancy runs 0..DEPTH inclusive, so one bit more than the address.
   function automatic int cnt_width(input int addr_w);
      return addr_w + 1;
   endfunction

endpackage

// File: rtl/fft_fifo_mem.sv
// Simple dual-port storage for the FFT FIFO: one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module fft_fifo_mem
   import fft_fifo_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] mem_array [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_array[waddr] <= wdata;
      end
   end

   assign rdata = mem_array[raddr];

endmodule

// File: rtl/fft_sync_fifo.sv
// Parametrised synchronous FIFO between FFT butterfly stages, one per lane.
// Optional sticky overflow/underflow flags are built when FFT_FIFO_ERR_FLAGS_EN is defined.
module fft_sync_fifo
   import fft_fifo_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int READ_LAT = RD_COMB,
   parameter int AFULL_TH = DEF_AFULL_TH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              w_en,
   input  logic [WIDTH-1:0]  data_in,
   input  logic              r_en,
   output logic [WIDTH-1:0]  data_out,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   count
`ifdef FFT_FIFO_ERR_FLAGS_EN
   ,
   input  logic              err_clr,
   output logic              overflow,
   output logic              underflow
`endif
);

   localparam int CNT_W = cnt_width(ADDR_W);
   localparam logic [CNT_W-1:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_TH);

   logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              wr_acc, rd_acc;
   logic [WIDTH-1:0]  rd_data;

   // Flags come straight from the count register, so they lag the access by a cycle.
   assign full        = (count_reg == DEPTH_C);
   assign empty       = (count_reg == '0);
   assign almost_full = (count_reg >= AFULL_C);
   assign count       = count_reg;

   // A write at full only goes through when a read frees the oldest slot.
   assign wr_acc = w_en & (~full | r_en);
   assign rd_acc = r_en & ~empty;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (wr_acc) begin
         wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
      end
      if (rd_acc) begin
         rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   fft_fifo_mem #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_reg),
      .wdata (data_in),
      .raddr (rd_ptr_reg),
      .rdata (rd_data)
   );

   generate
      if (READ_LAT == RD_COMB) begin : g_rd_comb
         assign data_out = rd_acc ? rd_data : '0;
         assign rd_valid = rd_acc;
      end else begin : g_rd_reg
         logic [WIDTH-1:0] data_out_reg;
         logic             rd_valid_reg;

         // Reset drops any read captured in the same cycle.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               data_out_reg <= '0;
               rd_valid_reg <= 1'b0;
            end else begin
               data_out_reg <= rd_acc ? rd_data : '0;
               rd_valid_reg <= rd_acc;
            end
         end

         assign data_out = data_out_reg;
         assign rd_valid = rd_valid_reg;
      end
   endgenerate

`ifdef FFT_FIFO_ERR_FLAGS_EN
   logic overflow_reg, underflow_reg;
   logic overflow_set, underflow_set;

   assign overflow_set  = w_en & full & ~r_en;
   assign underflow_set = r_en & empty;

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (overflow_set) begin
            overflow_reg <= 1'b1;
         end else if (err_clr) begin
            overflow_reg <= 1'b0;
         end
         if (underflow_set) begin
            underflow_reg <= 1'b1;
         end else if (err_clr) begin
            underflow_reg <= 1'b0;
         end
      end
   end

   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_fft_sync_fifo.sv
// Directed bench driving a combinational-read and a registered-read FIFO with
// identical stimulus, checked against a queue-based reference model.
module tb_fft_sync_fifo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        w_en = 1'b0;
   logic        r_en = 1'b0;
   logic [13:0] data_in = '0;

   logic [13:0] data_out0, data_out1;
   logic        rd_valid0, rd_valid1;
   logic        full0, full1, empty0, empty1, afull0, afull1;
   logic [3:0]  count0, count1;
`ifdef FFT_FIFO_ERR_FLAGS_EN
   logic        err_clr = 1'b0;
   logic        ovf0, unf0, ovf1, unf1;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [13:0] model_q[$];
   logic        pend_v = 1'b0;
   logic [13:0] pend_d = '0;

   always #5 clk = ~clk;

   fft_sync_fifo #(.WIDTH(14), .ADDR_W(3), .READ_LAT(0), .AFULL_TH(6)) dut0 (
      .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(data_out0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
      .almost_full(afull0), .count(count0)
`ifdef FFT_FIFO_ERR_FLAGS_EN
      , .err_clr(err_clr), .overflow(ovf0), .underflow(unf0)
`endif
   );

   fft_sync_fifo #(.WIDTH(14), .ADDR_W(3), .READ_LAT(1), .AFULL_TH(6)) dut1 (
      .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(data_out1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
      .almost_full(afull1), .count(count1)
`ifdef FFT_FIFO_ERR_FLAGS_EN
      , .err_clr(err_clr), .overflow(ovf1), .underflow(unf1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle of stimulus; outputs sampled on the falling edge.
   task automatic step(input logic w, input logic [13:0] d, input logic r);
      int          sz;
      logic        ra, wa;
      logic [13:0] ed;
      w_en    = w;
      data_in = d;
      r_en    = r;
      sz = model_q.size();
      ra = r && (sz > 0);
      wa = w && ((sz < 8) || r);
      ed = ra ? model_q[0] : 14'h0;
      @(negedge clk);
      $display("t=%0t w=%0b d=%04h r=%0b | cnt=%0d out0=%04h v0=%0b out1=%04h v1=%0b",
               $time, w, d, r, count0, data_out0, rd_valid0, data_out1, rd_valid1);
      chk("rd_valid0", {31'b0, rd_valid0}, {31'b0, ra});
      chk("data_out0", {18'b0, data_out0}, {18'b0, ed});
      chk("rd_valid1", {31'b0, rd_valid1}, {31'b0, pend_v});
      chk("data_out1", {18'b0, data_out1}, {18'b0, pend_d});
      chk("count0", {28'b0, count0}, sz);
      chk("count1", {28'b0, count1}, sz);
      chk("empty0", {31'b0, empty0}, {31'b0, sz == 0});
      chk("full0", {31'b0, full0}, {31'b0, sz == 8});
      chk("afull0", {31'b0, afull0}, {31'b0, sz >= 6});
      chk("empty1", {31'b0, empty1}, {31'b0, sz == 0});
      chk("full1", {31'b0, full1}, {31'b0, sz == 8});
      if (ra) void'(model_q.pop_front());
      if (wa) model_q.push_back(d);
      pend_v = ra;
      pend_d = ed;
      @(posedge clk);
      #1;
   endtask

   // Reset cycle; r may be high to leave a registered read in flight.
   task automatic do_reset(input logic r);
      rst_n = 1'b0;
      w_en  = 1'b0;
      r_en  = r;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      r_en  = 1'b0;
      model_q.delete();
      pend_v = 1'b0;
      pend_d = '0;
      $display("t=%0t reset applied (r_en=%0b)", $time, r);
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset(1'b0);

      // 1: idle after reset
      step(1'b0, 14'h0, 1'b0);
      step(1'b0, 14'h0, 1'b0);

      // 2: fill with 1..8, then drain
      for (int i = 1; i <= 8; i++) step(1'b1, 14'(i), 1'b0);
      // 3: write into full without a read is dropped
      step(1'b1, 14'h3FFF, 1'b0);
`ifdef FFT_FIFO_ERR_FLAGS_EN
      @(negedge clk);
      chk("overflow0", {31'b0, ovf0}, 32'd1);
      @(posedge clk);
      #1;
`endif
      for (int i = 0; i < 8; i++) step(1'b0, 14'h0, 1'b1);
      step(1'b0, 14'h0, 1'b0);

      // 4: read+write on empty rejects the read
      step(1'b1, 14'h0123, 1'b1);
      step(1'b0, 14'h0, 1'b1);
      step(1'b0, 14'h0, 1'b0);

      // 5: steady read+write at occupancy 4
      for (int i = 0; i < 4; i++) step(1'b1, 14'(16'h0100 + i), 1'b0);
      for (int i = 4; i < 24; i++) step(1'b1, 14'(16'h0100 + i), 1'b1);
      // read+write pair while full
      for (int i = 0; i < 4; i++) step(1'b1, 14'(16'h0200 + i), 1'b0);
      step(1'b1, 14'h0ABC, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 14'h0, 1'b1);

      // 6: reset with count=5 and a registered read in flight
      for (int i = 0; i < 5; i++) step(1'b1, 14'(16'h0300 + i), 1'b0);
      do_reset(1'b1);
      step(1'b0, 14'h0, 1'b1);
      step(1'b1, 14'h0155, 1'b0);
      step(1'b0, 14'h0, 1'b1);
      step(1'b0, 14'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fft_sync_fifo.md
Name: fft_sync_fifo

Overview:
Parametrised synchronous FIFO for the FFT datapath. Buffers butterfly outputs and reorders stage data between pipeline stages. It generalises the fixed 8-entry, 14-bit stage buffer in the following ways:
- configurable width and depth
- full/empty/count status
- protected pointers on illegal accesses
- selectable combinational or registered read path

It sits between butterfly stages and the twiddle multiplier, one instance per real/imag lane.

Parameters:
WIDTH, 14, data word width in bits (>=1)
ADDR_W, 3, log2 of depth; DEPTH = 2**ADDR_W entries (ADDR_W >= 1)
READ_LAT, 0, read latency: 0 = data_out valid in the same cycle as the accepted read; 1 = data_out registered, valid one cycle after
AFULL_TH, 6, almost_full asserts when count >= AFULL_TH (1..DEPTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
w_en  input  1  write request
data_in  input  WIDTH  write data
r_en  input  1  read request
data_out  output  WIDTH  read data; 0 whenever rd_valid is low
rd_valid  output  1  data_out carries an accepted read
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_TH
count  output  ADDR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset is synchronous (rst_n low at a clk edge). Clock and reset polarity/synchronicity are fixed: single clock clk, synchronous active-low reset rst_n.
- Values after reset:
  - wr_ptr = 0, rd_ptr = 0, count = 0
  - empty = 1, full = 0, almost_full = 0 (AFULL_TH >= 1)
  - rd_valid = 0, data_out = 0
- Storage array is not reset; output gating ensures no stale or X data appears on data_out.
- Reset mid-operation discards all contents; any in-flight registered read (READ_LAT=1) is dropped, so rd_valid = 0 on the next cycle.
- wr_acc = w_en & (~full | r_en). A write into a full FIFO is accepted only when paired with a read.
- rd_acc = r_en & ~empty. No fall-through: a read on an empty FIFO is rejected even if a write happens in the same cycle.
- Accepted write: mem[wr_ptr] <= data_in; wr_ptr increments mod DEPTH, wrapping naturally at ADDR_W bits.
- Accepted read: rd_ptr increments mod DEPTH.
- Count update:
  - count <= count + wr_acc - rd_acc
  - simultaneous accepted read and write leaves count unchanged
  - at full, a read+write pair reads the oldest entry and writes into the slot just vacated (wr_ptr == rd_ptr)
- Rejected accesses change neither pointers, count, nor memory.
- full, empty and almost_full decode combinationally from the count register, so they are glitch-free and update one cycle after the access.
- READ_LAT=0:
  - data_out = mem[rd_ptr] when rd_acc, else 0 (combinational)
  - rd_valid = rd_acc (combinational)
- READ_LAT=1:
  - data_out and rd_valid are registered
  - on the cycle after rd_acc: data_out = the entry read, rd_valid = 1
  - otherwise data_out = 0, rd_valid = 0
- Ordering is strictly first-in first-out across pointer wrap.

Optional Feature:
Macro FFT_FIFO_ERR_FLAGS_EN.
- Defined: adds outputs overflow and underflow (1 bit each) and input err_clr (1 bit).
  - overflow sets sticky when w_en & full & ~r_en.
  - underflow sets sticky when r_en & empty.
  - err_clr high clears both next edge; a set in the same cycle wins over the clear.
  - Both flags reset to 0.
- Undefined: the ports are absent and no error logic is built. Data behaviour is identical in both cases.

Decomposition:
- Package fft_fifo_pkg:
  - default WIDTH/ADDR_W constants
  - READ_LAT encoding constants (RD_COMB=0, RD_REG=1)
  - function computing count width
- Sub-module fft_fifo_mem: simple dual-port storage array with one write port and an asynchronous read port. It holds no pointers; pointer/flag logic stays in fft_sync_fifo.

Test Plan:
1. Reset then idle, WIDTH=14, ADDR_W=3 -> empty=1, count=0, data_out=0, rd_valid=0.
2. Write 8 words 0x0001..0x0008 -> full=1, count=8, almost_full asserted at count=6; then 8 reads -> data_out 0x0001..0x0008 in order with rd_valid=1 (READ_LAT=0 same cycle, READ_LAT=1 one cycle later), ending with empty=1.
3. Full FIFO, w_en=1 r_en=0 with data 0x3FFF -> write dropped, count stays 8, later reads never return 0x3FFF (with FFT_FIFO_ERR_FLAGS_EN: overflow=1).
4. Empty FIFO, w_en=1 and r_en=1 same cycle with 0x0123 -> read rejected, data_out=0, rd_valid=0, count=1; next read returns 0x0123.
5. 20 cycles of continuous read+write at count=4 with an incrementing pattern -> count stays 4, pointers wrap twice, output equals input delayed by 4 accepted reads.
6. rst_n low for one cycle while count=5 and a READ_LAT=1 read is in flight -> next cycle rd_valid=0, data_out=0, count=0, empty=1; old data is never emitted.
